vlsu_elem_sequencer: RTL and testbench

// - Upstream of vector_lsu. Splits one decoded vector load/store into 32-bit word beats.
// - Per beat: drives one single-cycle vlsu_en to the LSU, waits for vlsu_ready, then advances address and word index.
// - Supports unit-stride (any SEW) and strided (SEW=32 only). Pulses done or err at the end.

---
 rtl/vlsu_elem_sequencer_pkg.sv | 31 +++
 rtl/vlsu_elem_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_vlsu_elem_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vlsu_elem_sequencer_pkg.sv
// Shared types, constants and beat-count helper for the vector LSU element sequencer.
package vlsu_elem_sequencer_pkg;

    localparam int MAX_WORDS  = 32;
    localparam int IDX_W      = $clog2(MAX_WORDS);
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_ISSUE = 3'd1,
        SEQ_WAIT  = 3'd2,
        SEQ_DONE  = 3'd3,
        SEQ_ERR   = 3'd4
    } vlsu_seq_state_t;

    // Unit-stride packs elements into whole words; strided issues one word per element.
    function automatic logic [5:0] vlsu_beats(
        input logic [IDX_W-1:0] vl,
        input logic [1:0]       vsew,
        input logic             strided
    );
        logic [6:0] bytes;
        bytes = 7'(vl) << vsew;
        if (strided) begin
            vlsu_beats = 6'(vl);
        end else begin
            vlsu_beats = 6'((bytes + 7'd3) >> 2);
        end
    endfunction

endpackage

// File: rtl/vlsu_elem_sequencer.sv
// Splits one vector load/store into 32-bit word beats for the vector LSU.
// Optional build macro VLSU_SEQ_ALIGN_CHK_EN rejects misaligned base/stride at start.
module vlsu_elem_sequencer
    import vlsu_elem_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             load_i,
    input  logic             store_i,
    input  logic             strided_i,
    input  logic [IDX_W-1:0] vl_i,
    input  logic [1:0]       vsew_i,
    input  logic [31:0]      base_i,
    input  logic [31:0]      stride_i,
    input  logic [4:0]       vd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             vlsu_en_o,
    output logic             vlsu_load_o,
    output logic             vlsu_store_o,
    input  logic             vlsu_ready_i,
    output logic [31:0]      op0_data_o,
    output logic [IDX_W-1:0] vr_addr_o,
    output logic [4:0]       vreg_o
);

    vlsu_seq_state_t  state_r;
    vlsu_seq_state_t  state_next_s;

    logic             load_r;
    logic             store_r;
    logic             strided_r;
    logic [31:0]      stride_r;
    logic [5:0]       beats_r;
    logic [31:0]      addr_r;
    logic [IDX_W-1:0] idx_r;
    logic [4:0]       vd_r;
    logic [4:0]       vreg_r;

    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             en_r;
    logic             load_out_r;
    logic             store_out_r;

    logic             accept_s;
    logic             reject_s;
    logic             latch_s;
    logic             advance_s;
    logic             last_beat_s;
    logic             hold_op_s;
    logic             load_s;
    logic             store_s;
    logic [5:0]       beats_in_s;
    logic [IDX_W-1:0] idx_inc_s;

    assign idx_inc_s   = idx_r + 5'd1;
    assign last_beat_s = (6'(idx_r) + 6'd1) == beats_r;

    // Start qualification, beat count and rejection of unsupported encodings.
    always_comb begin
        accept_s   = start_i && (load_i || store_i);
        beats_in_s = vlsu_beats(vl_i, vsew_i, strided_i);
        reject_s   = (vsew_i == 2'd3) || (strided_i && (vsew_i != 2'd2));
`ifdef VLSU_SEQ_ALIGN_CHK_EN
        if ((base_i[1:0] != 2'b00) || (strided_i && (stride_i[1:0] != 2'b00))) begin
            reject_s = 1'b1;
        end else begin
            reject_s = reject_s;
        end
`endif
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (accept_s) begin
                    latch_s = 1'b1;
                    if (reject_s) begin
                        state_next_s = SEQ_ERR;
                    end else if (beats_in_s == 6'd0) begin
                        state_next_s = SEQ_DONE;
                    end else begin
                        state_next_s = SEQ_ISSUE;
                    end
                end else begin
                    state_next_s = SEQ_IDLE;
                end
            end
            SEQ_ISSUE: state_next_s = SEQ_WAIT;
            SEQ_WAIT: begin
                if (vlsu_ready_i) begin
                    if (last_beat_s) begin
                        state_next_s = SEQ_DONE;
                    end else begin
                        advance_s    = 1'b1;
                        state_next_s = SEQ_ISSUE;
                    end
                end else begin
                    state_next_s = SEQ_WAIT;
                end
            end
            SEQ_DONE: state_next_s = SEQ_IDLE;
            SEQ_ERR:  state_next_s = SEQ_IDLE;
            default:  state_next_s = SEQ_IDLE;
        endcase
    end

    // Op-type qualifiers seen by the output registers; load wins over store.
    always_comb begin
        hold_op_s = (state_next_s == SEQ_ISSUE) || (state_next_s == SEQ_WAIT) ||
                    (state_next_s == SEQ_DONE);
        if (latch_s) begin
            load_s  = load_i;
            store_s = store_i && !load_i;
        end else begin
            load_s  = load_r;
            store_s = store_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= SEQ_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output registers are loaded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            en_r        <= 1'b0;
            load_out_r  <= 1'b0;
            store_out_r <= 1'b0;
        end else begin
            busy_r      <= state_next_s != SEQ_IDLE;
            done_r      <= state_next_s == SEQ_DONE;
            err_r       <= state_next_s == SEQ_ERR;
            en_r        <= state_next_s == SEQ_ISSUE;
            load_out_r  <= hold_op_s && load_s;
            store_out_r <= hold_op_s && store_s;
        end
    end

    // Instruction latch plus address/index accumulators; the address wraps at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_r    <= 1'b0;
            store_r   <= 1'b0;
            strided_r <= 1'b0;
            stride_r  <= 32'd0;
            beats_r   <= 6'd0;
            addr_r    <= 32'd0;
            idx_r     <= 5'd0;
            vd_r      <= 5'd0;
            vreg_r    <= 5'd0;
        end else if (latch_s) begin
            load_r    <= load_s;
            store_r   <= store_s;
            strided_r <= strided_i;
            stride_r  <= stride_i;
            beats_r   <= beats_in_s;
            addr_r    <= base_i;
            idx_r     <= 5'd0;
            vd_r      <= vd_i;
            vreg_r    <= vd_i;
        end else if (advance_s) begin
            addr_r    <= addr_r + (strided_r ? stride_r : 32'(WORD_BYTES));
            idx_r     <= idx_inc_s;
            vreg_r    <= vd_r + {2'b00, idx_inc_s[4:2]};
        end else begin
            addr_r    <= addr_r;
            idx_r     <= idx_r;
            vreg_r    <= vreg_r;
        end
    end

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign vlsu_en_o    = en_r;
    assign vlsu_load_o  = load_out_r;
    assign vlsu_store_o = store_out_r;
    assign op0_data_o   = addr_r;
    assign vr_addr_o    = idx_r;
    assign vreg_o       = vreg_r;

endmodule

// File: tb/tb_vlsu_elem_sequencer.sv
// Directed self-checking bench for vlsu_elem_sequencer; a behavioural LSU answers each beat.
module tb_vlsu_elem_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i, load_i, store_i, strided_i;
    logic [4:0]  vl_i;
    logic [1:0]  vsew_i;
    logic [31:0] base_i, stride_i;
    logic [4:0]  vd_i;
    logic        busy_o, done_o, err_o, vlsu_en_o, vlsu_load_o, vlsu_store_o;
    logic        vlsu_ready_i;
    logic [31:0] op0_data_o;
    logic [4:0]  vr_addr_o, vreg_o;

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0;
    int en_base;

    vlsu_elem_sequencer dut (
        .clk(clk), .reset(reset), .start_i(start_i), .load_i(load_i), .store_i(store_i),
        .strided_i(strided_i), .vl_i(vl_i), .vsew_i(vsew_i), .base_i(base_i),
        .stride_i(stride_i), .vd_i(vd_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .vlsu_en_o(vlsu_en_o), .vlsu_load_o(vlsu_load_o), .vlsu_store_o(vlsu_store_o),
        .vlsu_ready_i(vlsu_ready_i), .op0_data_o(op0_data_o), .vr_addr_o(vr_addr_o),
        .vreg_o(vreg_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vlsu_en_o === 1'b1) en_cnt <= en_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic ld, input logic st, input logic sd, input logic [4:0] vl,
                          input logic [1:0] sew, input logic [31:0] base,
                          input logic [31:0] stride, input logic [4:0] vd);
        start_i = 1'b1; load_i = ld; store_i = st; strided_i = sd; vl_i = vl;
        vsew_i = sew; base_i = base; stride_i = stride; vd_i = vd;
        tick();
        start_i = 1'b0; load_i = 1'b0; store_i = 1'b0; strided_i = 1'b0;
        vl_i = 5'd0; vsew_i = 2'd0; base_i = 32'hDEAD_BEEF; stride_i = 32'h0; vd_i = 5'd0;
    endtask

    // Called in the ISSUE cycle; leaves the bench in the cycle after the ready edge.
    task automatic beat(input logic [31:0] a, input int idx, input int vreg,
                        input logic ld, input logic st, input int waits);
        chk("en_issue", {31'd0, vlsu_en_o}, 32'd1);
        chk("addr", op0_data_o, a);
        chk("vr_addr", {27'd0, vr_addr_o}, idx[31:0]);
        chk("vreg", {27'd0, vreg_o}, vreg[31:0]);
        chk("load", {31'd0, vlsu_load_o}, {31'd0, ld});
        chk("store", {31'd0, vlsu_store_o}, {31'd0, st});
        chk("busy", {31'd0, busy_o}, 32'd1);
        tick();
        for (int w = 0; w < waits; w++) begin
            chk("en_wait", {31'd0, vlsu_en_o}, 32'd0);
            tick();
        end
        chk("en_wait", {31'd0, vlsu_en_o}, 32'd0);
        chk("addr_hold", op0_data_o, a);
        chk("idx_hold", {27'd0, vr_addr_o}, idx[31:0]);
        vlsu_ready_i = 1'b1;
        tick();
        vlsu_ready_i = 1'b0;
    endtask

    task automatic expect_end(input string tag, input logic dn, input logic er);
        chk({tag, "_done"}, {31'd0, done_o}, {31'd0, dn});
        chk({tag, "_err"}, {31'd0, err_o}, {31'd0, er});
        chk({tag, "_en"}, {31'd0, vlsu_en_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        tick();
        chk({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_idle_err"}, {31'd0, err_o}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; load_i = 1'b0; store_i = 1'b0; strided_i = 1'b0;
        vl_i = 5'd0; vsew_i = 2'd0; base_i = 32'd0; stride_i = 32'd0; vd_i = 5'd0;
        vlsu_ready_i = 1'b0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_en", {31'd0, vlsu_en_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_addr", op0_data_o, 32'd0);
        chk("rst_vreg", {27'd0, vreg_o}, 32'd0);
        reset = 1'b0;
        tick();

        // start without load/store is ignored
        launch(1'b0, 1'b0, 1'b0, 5'd4, 2'd2, 32'h40, 32'd0, 5'd0);
        chk("nop_busy", {31'd0, busy_o}, 32'd0);
        chk("nop_en", {31'd0, vlsu_en_o}, 32'd0);

        // unit load, vl=8 SEW8: 2 beats, done in the 6th cycle counting the start cycle
        en_base = en_cnt;
        launch(1'b1, 1'b0, 1'b0, 5'd8, 2'd0, 32'h100, 32'd0, 5'd2);
        beat(32'h100, 0, 2, 1'b1, 1'b0, 0);
        beat(32'h104, 1, 2, 1'b1, 1'b0, 0);
        chk("u8_en_cnt", en_cnt - en_base, 32'd2);
        expect_end("u8", 1'b1, 1'b0);

        // unit store, vl=5 SEW8: 2 beats, both load and store asserted -> load wins
        launch(1'b1, 1'b1, 1'b0, 5'd5, 2'd0, 32'h300, 32'd0, 5'd0);
        beat(32'h300, 0, 0, 1'b1, 1'b0, 1);
        beat(32'h304, 1, 0, 1'b1, 1'b0, 2);
        expect_end("u5", 1'b1, 1'b0);

        // strided store, stride 0x10, SEW32
        en_base = en_cnt;
        launch(1'b0, 1'b1, 1'b1, 5'd3, 2'd2, 32'h200, 32'h10, 5'd1);
        beat(32'h200, 0, 1, 1'b0, 1'b1, 0);
        beat(32'h210, 1, 1, 1'b0, 1'b1, 3);
        beat(32'h220, 2, 1, 1'b0, 1'b1, 0);
        chk("st_en_cnt", en_cnt - en_base, 32'd3);
        expect_end("st", 1'b1, 1'b0);

        // negative stride wraps
        launch(1'b1, 1'b0, 1'b1, 5'd3, 2'd2, 32'h8, 32'hFFFF_FFFC, 5'd0);
        beat(32'h8, 0, 0, 1'b1, 1'b0, 0);
        beat(32'h4, 1, 0, 1'b1, 1'b0, 0);
        beat(32'h0, 2, 0, 1'b1, 1'b0, 0);
        expect_end("neg", 1'b1, 1'b0);

        // vl=0 completes immediately with no beats
        en_base = en_cnt;
        launch(1'b1, 1'b0, 1'b0, 5'd0, 2'd2, 32'h500, 32'd0, 5'd0);
        expect_end("vl0", 1'b1, 1'b0);
        chk("vl0_en_cnt", en_cnt - en_base, 32'd0);

        // strided SEW16 and reserved SEW are rejected
        en_base = en_cnt;
        launch(1'b1, 1'b0, 1'b1, 5'd3, 2'd1, 32'h600, 32'h8, 5'd0);
        expect_end("err16", 1'b0, 1'b1);
        launch(1'b0, 1'b1, 1'b0, 5'd3, 2'd3, 32'h600, 32'h0, 5'd0);
        expect_end("err3", 1'b0, 1'b1);
        chk("err_en_cnt", en_cnt - en_base, 32'd0);

        // longest instruction, vd=4; a stray start mid-run must be dropped
        en_base = en_cnt;
        launch(1'b1, 1'b0, 1'b0, 5'd31, 2'd2, 32'h1000, 32'd0, 5'd4);
        for (int i = 0; i < 31; i++) begin
            if (i == 5) begin
                start_i = 1'b1; store_i = 1'b1; strided_i = 1'b1; base_i = 32'h9000;
            end else begin
                start_i = 1'b0; store_i = 1'b0; strided_i = 1'b0;
            end
            beat(32'h1000 + 32'(4 * i), i, (4 + (i >> 2)) & 31, 1'b1, 1'b0, i % 3);
        end
        start_i = 1'b0; store_i = 1'b0; strided_i = 1'b0;
        chk("long_en_cnt", en_cnt - en_base, 32'd31);
        expect_end("long", 1'b1, 1'b0);

        // reset during WAIT of beat 1
        launch(1'b1, 1'b0, 1'b0, 5'd8, 2'd2, 32'h700, 32'd0, 5'd0);
        beat(32'h700, 0, 0, 1'b1, 1'b0, 0);
        chk("rstmid_en", {31'd0, vlsu_en_o}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
        chk("rstmid_done", {31'd0, done_o}, 32'd0);
        chk("rstmid_load", {31'd0, vlsu_load_o}, 32'd0);
        chk("rstmid_addr", op0_data_o, 32'd0);
        chk("rstmid_idx", {27'd0, vr_addr_o}, 32'd0);
        tick();
        chk("rstmid_done2", {31'd0, done_o}, 32'd0);
        chk("rstmid_busy2", {31'd0, busy_o}, 32'd0);

        // misaligned base
        launch(1'b1, 1'b0, 1'b0, 5'd4, 2'd2, 32'h102, 32'd0, 5'd0);
`ifdef VLSU_SEQ_ALIGN_CHK_EN
        expect_end("align", 1'b0, 1'b1);
`else
        for (int i = 0; i < 4; i++) begin
            beat(32'h102 + 32'(4 * i), i, 0, 1'b1, 1'b0, 0);
        end
        expect_end("noalign", 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
